// File: rtl/state_table_loader.sv
// Loop/state table loader: fills a register-file table from a host valid/ready
// stream, then hands it to the loop-sequencing FSM until that FSM reports done.
module state_table_loader #(
  parameter int ENTRY_W = 48,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENTRY_W-1:0]   s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [ADDR_W-1:0]    smart_ptr,
  input  logic                 done,
  output logic [ENTRY_W-1:0]   entry_table,
  output logic                 start_inbound,
  output logic [ADDR_W:0]      entry_count,
  output logic                 busy,
  output logic                 load_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]          state_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W:0]     count_r;
  logic                load_err_r;
  logic                start_r;
  logic [ENTRY_W-1:0]  mem_r [DEPTH];

  logic                accept_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [ENTRY_W-1:0]  rd_data_s;

  // Handshake and table write port decode.
  always_comb begin
    accept_s  = s_tvalid & (state_r != ST_RUN);
    wr_en_s   = 1'b0;
    wr_addr_s = wr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        wr_en_s   = accept_s;
        wr_addr_s = PTR_ZERO;
      end
      ST_LOAD: wr_en_s = accept_s;
      default: wr_en_s = 1'b0;
    endcase
  end

  // Table storage; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= s_tdata;
    end
  end

  // Load/run sequencing, fill pointer, entry count and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      load_err_r <= 1'b0;
      start_r    <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            wr_ptr_r   <= PTR_ONE;
            count_r    <= CNT_ONE;
            load_err_r <= 1'b0;
            if (s_tlast) begin
              state_r <= ST_RUN;
              start_r <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            count_r  <= count_r + CNT_ONE;
            if (s_tlast) begin
              state_r <= ST_RUN;
              start_r <= 1'b1;
            end else if (wr_ptr_r == PTR_LAST) begin
              // Table full without a terminating beat: swallow the rest.
              state_r    <= ST_DRAIN;
              load_err_r <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept_s && s_tlast) begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (done) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Zero past the loaded entries so the FSM always sees a valid=0 terminator.
  always_comb begin
    rd_data_s = {ENTRY_W{1'b0}};
    if ((state_r == ST_RUN) && ({1'b0, smart_ptr} < count_r)) begin
      rd_data_s = mem_r[smart_ptr];
    end else begin
      rd_data_s = {ENTRY_W{1'b0}};
    end
  end

  assign s_tready      = (state_r != ST_RUN);
  assign busy          = (state_r == ST_RUN);
  assign entry_table   = rd_data_s;
  assign start_inbound = start_r;
  assign entry_count   = count_r;
  assign load_err      = load_err_r;

endmodule

// File: tb/tb_state_table_loader.sv
// Bench for state_table_loader: queue-based table model checked every cycle,
// directed scenarios with literal expectations, then randomized tables.
module tb_state_table_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [4:0]  smart_ptr;
  logic        done;
  logic [47:0] entry_table;
  logic        start_inbound;
  logic [5:0]  entry_count;
  logic        busy;
  logic        load_err;

  always #5 clk = ~clk;

  state_table_loader dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .smart_ptr(smart_ptr), .done(done),
    .entry_table(entry_table), .start_inbound(start_inbound),
    .entry_count(entry_count), .busy(busy), .load_err(load_err)
  );

  int total = 0;
  int bad   = 0;

  // Model: the table is a queue of accepted words; flags say what phase we are in.
  logic [47:0] tbl[$];
  bit m_run, m_loading, m_drop, m_err, m_pulse;

  logic [47:0] w3   [3];
  logic [47:0] w32  [32];
  logic [47:0] wtmp;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic model_reset();
    tbl.delete();
    m_run = 0; m_loading = 0; m_drop = 0; m_err = 0; m_pulse = 0;
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    bit pulse;
    logic [47:0] exp_tab;
    @(posedge clk);
    pulse = 0;
    if (m_run) begin
      if (done) m_run = 0;
    end else if (s_tvalid) begin
      if (m_drop) begin
        if (s_tlast) m_drop = 0;
      end else begin
        if (!m_loading) begin
          tbl.delete();
          m_err = 0;
          m_loading = 1;
        end
        tbl.push_back(s_tdata);
        if (s_tlast) begin
          m_loading = 0; m_run = 1; pulse = 1;
        end else if (tbl.size() == 32) begin
          m_loading = 0; m_drop = 1; m_err = 1;
        end
      end
    end
    m_pulse = pulse;
    @(negedge clk);
    exp_tab = (m_run && (int'(smart_ptr) < tbl.size())) ? tbl[smart_ptr] : 48'd0;
    chk("s_tready", {47'd0, s_tready}, {47'd0, !m_run});
    chk("busy", {47'd0, busy}, {47'd0, m_run});
    chk("start_inbound", {47'd0, start_inbound}, {47'd0, m_pulse});
    chk("load_err", {47'd0, load_err}, {47'd0, m_err});
    chk("entry_count", {42'd0, entry_count}, 48'(tbl.size()));
    chk("entry_table", entry_table, exp_tab);
  endtask

  task automatic send(input logic [47:0] w, input bit last);
    s_tdata = w; s_tlast = last; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = rnd48();
  endtask

  task automatic run_for(input int n);
    repeat (n) begin
      smart_ptr = 5'($urandom_range(0, 31));
      tick();
    end
  endtask

  task automatic finish_run();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {47'd0, s_tready}, 48'd1);
    chk({tag, "_busy"}, {47'd0, busy}, 48'd0);
    chk({tag, "_start"}, {47'd0, start_inbound}, 48'd0);
    chk({tag, "_err"}, {47'd0, load_err}, 48'd0);
    chk({tag, "_count"}, {42'd0, entry_count}, 48'd0);
    chk({tag, "_table"}, entry_table, 48'd0);
  endtask

  initial begin
    s_tdata = 48'd0; s_tvalid = 1'b0; s_tlast = 1'b0; smart_ptr = 5'd0; done = 1'b0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Three-word table.
    foreach (w3[i]) w3[i] = rnd48();
    send(w3[0], 1'b0);
    send(w3[1], 1'b0);
    send(w3[2], 1'b1);
    chk("t3_start", {47'd0, start_inbound}, 48'd1);
    chk("t3_count", {42'd0, entry_count}, 48'd3);
    smart_ptr = 5'd1;
    #1 chk("t3_ptr1", entry_table, w3[1]);
    smart_ptr = 5'd3;
    #1 chk("t3_ptr3", entry_table, 48'd0);
    tick();
    chk("t3_pulse_once", {47'd0, start_inbound}, 48'd0);
    smart_ptr = 5'd1;
    finish_run();
    chk("done_busy", {47'd0, busy}, 48'd0);
    chk("done_ready", {47'd0, s_tready}, 48'd1);
    chk("done_table", entry_table, 48'd0);
    finish_run();
    chk("idle_done_ready", {47'd0, s_tready}, 48'd1);
    chk("idle_done_busy", {47'd0, busy}, 48'd0);

    // Single-word table.
    wtmp = rnd48();
    send(wtmp, 1'b1);
    chk("t1_count", {42'd0, entry_count}, 48'd1);
    chk("t1_busy", {47'd0, busy}, 48'd1);
    smart_ptr = 5'd0;
    #1 chk("t1_ptr0", entry_table, wtmp);
    run_for(3);
    finish_run();

    // Full 32-word table.
    foreach (w32[i]) w32[i] = rnd48();
    for (int k = 0; k < 32; k++) send(w32[k], k == 31);
    chk("t32_count", {42'd0, entry_count}, 48'd32);
    chk("t32_err", {47'd0, load_err}, 48'd0);
    chk("t32_busy", {47'd0, busy}, 48'd1);
    smart_ptr = 5'd31;
    #1 chk("t32_ptr31", entry_table, w32[31]);
    run_for(8);
    finish_run();

    // Overflow: 34 words, tlast on the last one.
    for (int k = 0; k < 34; k++) send(rnd48(), k == 33);
    chk("ovf_err", {47'd0, load_err}, 48'd1);
    chk("ovf_busy", {47'd0, busy}, 48'd0);
    chk("ovf_ready", {47'd0, s_tready}, 48'd1);
    send(rnd48(), 1'b0);
    chk("ovf_err_clr", {47'd0, load_err}, 48'd0);
    send(rnd48(), 1'b1);
    chk("ovf_next_start", {47'd0, start_inbound}, 48'd1);
    chk("ovf_next_count", {42'd0, entry_count}, 48'd2);
    run_for(2);
    finish_run();

    // Asynchronous reset in the middle of a load.
    for (int k = 0; k < 5; k++) send(rnd48(), 1'b0);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("mid");
    #1 rst = 1'b1;
    model_reset();
    send(rnd48(), 1'b0);
    send(rnd48(), 1'b1);
    chk("mid_next_count", {42'd0, entry_count}, 48'd2);
    finish_run();

    // Randomized tables, gaps, stray done pulses and random read pointers.
    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 36);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            done = 1'($urandom_range(0, 1));
            smart_ptr = 5'($urandom_range(0, 31));
            tick();
          end
          done = 1'b0;
        end
        send(rnd48(), i == len - 1);
      end
      if (m_run) begin
        run_for($urandom_range(1, 40));
        finish_run();
      end
      run_for($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
